byte_serializer: RTL and testbench

Parallel-in, serial-out byte serializer with valid/ready handshakes on both sides. It captures a frame of four bytes in one cycle and emits them one byte per cycle, oldest-tap first (Din3, Din2, Din1, Din0). A 4-tap byte delay line fed from this output and clocked only on accepted words holds Dout0..Dout3 = Din0..Din3 once the frame completes. The block sits on the transmit side of the byte datapath and feeds the tap-based receive chain.

---
 rtl/byte_serializer_if.sv | 25 ++
 rtl/byte_serializer.sv | 66 ++++++
 tb/tb_byte_serializer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/byte_serializer_if.sv
// Handshake bundle for byte_serializer: parallel frame load side and serial word output side.
interface byte_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] Din0;
  logic [WIDTH-1:0] Din1;
  logic [WIDTH-1:0] Din2;
  logic [WIDTH-1:0] Din3;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] Dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             dout_last;

  modport master (
    output Din0, Din1, Din2, Din3, load_valid, dout_ready,
    input  load_ready, Dout, dout_valid, dout_last
  );

  modport slave (
    input  Din0, Din1, Din2, Din3, load_valid, dout_ready,
    output load_ready, Dout, dout_valid, dout_last
  );
endinterface

// File: rtl/byte_serializer.sv
// Four-word parallel-in, serial-out serializer; emits Din3 first, Din0 last, one word per cycle.
module byte_serializer #(
  parameter int unsigned WIDTH = 8
) (
  input logic          clk,
  input logic          reset,
  byte_serializer_if.slave bus
);

  typedef enum logic {StIdle, StShift} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] stage_q [3];
  logic [1:0]       cnt_q;
  logic             last_q;

  logic dout_valid;
  logic load_ready;
  logic load_accept;
  logic consume;

  assign dout_valid  = (state_q == StShift);
  // A new frame may enter on the same edge the final word leaves, avoiding a bubble.
  assign load_ready  = !dout_valid || (bus.dout_ready && last_q);
  assign load_accept = bus.load_valid && load_ready;
  assign consume     = dout_valid && bus.dout_ready;

  assign bus.load_ready = load_ready;
  assign bus.Dout       = dout_q;
  assign bus.dout_valid = dout_valid;
  assign bus.dout_last  = last_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      dout_q     <= '0;
      stage_q[0] <= '0;
      stage_q[1] <= '0;
      stage_q[2] <= '0;
      cnt_q      <= 2'd0;
      last_q     <= 1'b0;
    end else if (load_accept) begin
      state_q    <= StShift;
      dout_q     <= bus.Din3;
      stage_q[0] <= bus.Din2;
      stage_q[1] <= bus.Din1;
      stage_q[2] <= bus.Din0;
      cnt_q      <= 2'd3;
      last_q     <= 1'b0;
    end else if (consume) begin
      if (cnt_q == 2'd0) begin
        state_q <= StIdle;
        last_q  <= 1'b0;
      end else begin
        dout_q     <= stage_q[0];
        stage_q[0] <= stage_q[1];
        stage_q[1] <= stage_q[2];
        stage_q[2] <= '0;
        cnt_q      <= cnt_q - 2'd1;
        last_q     <= (cnt_q == 2'd1);
      end
    end
  end

endmodule

// File: tb/tb_byte_serializer.sv
// Bench for byte_serializer: queue-based reference model, per-cycle compare, directed and random traffic.
module tb_byte_serializer;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  byte_serializer_if #(.WIDTH(8)) bus ();

  byte_serializer #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: words still owed downstream, head is the word on Dout.
  logic [7:0] q [$];
  bit         m_zero;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model update one time unit before each rising edge, from the inputs about to be sampled.
  initial begin
    q.delete();
    m_zero = 1'b1;
    forever begin
      @(negedge clk);
      #4;
      if (!reset) begin
        q.delete();
        m_zero = 1'b1;
      end else begin
        bit mv, ml, acc;
        mv  = (q.size() != 0);
        ml  = (q.size() == 1);
        acc = bus.load_valid && (!mv || (bus.dout_ready && ml));
        if (mv && bus.dout_ready) void'(q.pop_front());
        if (acc) begin
          q.push_back(bus.Din3);
          q.push_back(bus.Din2);
          q.push_back(bus.Din1);
          q.push_back(bus.Din0);
          m_zero = 1'b0;
        end
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      begin
        bit ev, el;
        ev = (q.size() != 0);
        el = (q.size() == 1);
        chk("dout_valid", {31'd0, bus.dout_valid}, {31'd0, ev});
        chk("dout_last", {31'd0, bus.dout_last}, {31'd0, el});
        chk("load_ready", {31'd0, bus.load_ready}, {31'd0, (!ev || (bus.dout_ready && el))});
        if (ev) chk("dout", {24'd0, bus.Dout}, {24'd0, q[0]});
        else if (m_zero) chk("dout_rst", {24'd0, bus.Dout}, 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic lit(input string name, input bit v, input logic [7:0] d, input bit l,
                     input bit lr);
    chk({name, ".valid"}, {31'd0, bus.dout_valid}, {31'd0, v});
    if (v) chk({name, ".dout"}, {24'd0, bus.Dout}, {24'd0, d});
    chk({name, ".last"}, {31'd0, bus.dout_last}, {31'd0, l});
    chk({name, ".ready"}, {31'd0, bus.load_ready}, {31'd0, lr});
  endtask

  task automatic set_frame(input logic [7:0] base);
    bus.Din3 = base + 8'h3;
    bus.Din2 = base + 8'h2;
    bus.Din1 = base + 8'h1;
    bus.Din0 = base;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b0;
    bus.load_valid = 1'b0;
    bus.dout_ready = 1'b0;
    set_frame(8'h00);

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      bus.load_valid = 1'($urandom);
      bus.dout_ready = 1'($urandom);
      set_frame(8'($urandom));
      step();
      chk("rst.dout", {24'd0, bus.Dout}, 32'd0);
      lit("rst", 1'b0, 8'h00, 1'b0, 1'b1);
    end
    reset = 1'b1;
    bus.load_valid = 1'b0;
    bus.dout_ready = 1'b1;
    step();

    // Single frame.
    bus.load_valid = 1'b1;
    set_frame(8'hA0);
    step();
    lit("single1", 1'b1, 8'hA3, 1'b0, 1'b0);
    bus.load_valid = 1'b0;
    step(); lit("single2", 1'b1, 8'hA2, 1'b0, 1'b0);
    step(); lit("single3", 1'b1, 8'hA1, 1'b0, 1'b0);
    step(); lit("single4", 1'b1, 8'hA0, 1'b1, 1'b1);
    step(); lit("single5", 1'b0, 8'h00, 1'b0, 1'b1);

    // Backpressure on 0xA2.
    bus.load_valid = 1'b1;
    step(); lit("bp1", 1'b1, 8'hA3, 1'b0, 1'b0);
    bus.load_valid = 1'b0;
    step(); lit("bp2", 1'b1, 8'hA2, 1'b0, 1'b0);
    bus.dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); lit("bp_stall", 1'b1, 8'hA2, 1'b0, 1'b0);
    end
    bus.dout_ready = 1'b1;
    step(); lit("bp3", 1'b1, 8'hA1, 1'b0, 1'b0);
    step(); lit("bp4", 1'b1, 8'hA0, 1'b1, 1'b1);
    step(); lit("bp5", 1'b0, 8'h00, 1'b0, 1'b1);

    // Back-to-back frames with load_valid held high.
    bus.load_valid = 1'b1;
    step(); lit("b2b1", 1'b1, 8'hA3, 1'b0, 1'b0);
    step(); lit("b2b2", 1'b1, 8'hA2, 1'b0, 1'b0);
    step(); lit("b2b3", 1'b1, 8'hA1, 1'b0, 1'b0);
    step(); lit("b2b4", 1'b1, 8'hA0, 1'b1, 1'b1);
    set_frame(8'hB0);
    step(); lit("b2b5", 1'b1, 8'hB3, 1'b0, 1'b0);
    bus.load_valid = 1'b0;
    step(); lit("b2b6", 1'b1, 8'hB2, 1'b0, 1'b0);
    step(); lit("b2b7", 1'b1, 8'hB1, 1'b0, 1'b0);
    step(); lit("b2b8", 1'b1, 8'hB0, 1'b1, 1'b1);
    step(); lit("b2b9", 1'b0, 8'h00, 1'b0, 1'b1);

    // Busy reject: frame C offered while A is stalled mid-shift.
    set_frame(8'hA0);
    bus.load_valid = 1'b1;
    step(); lit("busy1", 1'b1, 8'hA3, 1'b0, 1'b0);
    bus.dout_ready = 1'b0;
    set_frame(8'hC0);
    step(); lit("busy2", 1'b1, 8'hA3, 1'b0, 1'b0);
    step(); lit("busy3", 1'b1, 8'hA3, 1'b0, 1'b0);
    bus.dout_ready = 1'b1;
    step(); lit("busy4", 1'b1, 8'hA2, 1'b0, 1'b0);
    step(); lit("busy5", 1'b1, 8'hA1, 1'b0, 1'b0);
    step(); lit("busy6", 1'b1, 8'hA0, 1'b1, 1'b1);
    step(); lit("busy7", 1'b1, 8'hC3, 1'b0, 1'b0);
    bus.load_valid = 1'b0;
    step(); lit("busy8", 1'b1, 8'hC2, 1'b0, 1'b0);
    step(); lit("busy9", 1'b1, 8'hC1, 1'b0, 1'b0);
    step(); lit("busy10", 1'b1, 8'hC0, 1'b1, 1'b1);
    step(); lit("busy11", 1'b0, 8'h00, 1'b0, 1'b1);

    // Reset mid-frame after 0xA3 and 0xA2 are consumed.
    set_frame(8'hA0);
    bus.load_valid = 1'b1;
    step(); lit("mrst1", 1'b1, 8'hA3, 1'b0, 1'b0);
    bus.load_valid = 1'b0;
    step(); lit("mrst2", 1'b1, 8'hA2, 1'b0, 1'b0);
    step(); lit("mrst3", 1'b1, 8'hA1, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    chk("mrst_async.dout", {24'd0, bus.Dout}, 32'd0);
    lit("mrst_async", 1'b0, 8'h00, 1'b0, 1'b1);
    step(); lit("mrst_hold", 1'b0, 8'h00, 1'b0, 1'b1);
    reset = 1'b1;
    set_frame(8'hD0);
    bus.load_valid = 1'b1;
    step(); lit("mrst4", 1'b1, 8'hD3, 1'b0, 1'b0);
    bus.load_valid = 1'b0;
    step(); lit("mrst5", 1'b1, 8'hD2, 1'b0, 1'b0);
    step(); lit("mrst6", 1'b1, 8'hD1, 1'b0, 1'b0);
    step(); lit("mrst7", 1'b1, 8'hD0, 1'b1, 1'b1);
    step(); lit("mrst8", 1'b0, 8'h00, 1'b0, 1'b1);

    // Random traffic with occasional resets; the compare process does the checking.
    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(0, 249) != 0);
      bus.load_valid = ($urandom_range(0, 3) != 0);
      bus.dout_ready = ($urandom_range(0, 3) != 0);
      bus.Din0       = 8'($urandom);
      bus.Din1       = 8'($urandom);
      bus.Din2       = 8'($urandom);
      bus.Din3       = 8'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
